// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, ID/EX
// control-word bit positions and the ID/EX pipeline word layout.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // Base ops fit in 0..7 so that the M extension can own 8..15 as
    // {1'b1, funct3}. XOR/OR/AND share ALU_LOGIC; EX picks one with funct3.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_SRL    = 4'd5,
        ALU_SRA    = 4'd6,
        ALU_LOGIC  = 4'd7,
        ALU_MUL    = 4'd8,
        ALU_MULH   = 4'd9,
        ALU_MULHSU = 4'd10,
        ALU_MULHU  = 4'd11,
        ALU_DIV    = 4'd12,
        ALU_DIVU   = 4'd13,
        ALU_REM    = 4'd14,
        ALU_REMU   = 4'd15
    } alu_op_e;

    localparam int CTRL_W         = 13;
    localparam int CTRL_ILLEGAL   = 0;
    localparam int CTRL_LINK      = 1;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_MEM_WRITE = 3;
    localparam int CTRL_MEM_READ  = 4;
    localparam int CTRL_SRC_IMM   = 5;
    localparam int CTRL_FUNCT3_LO = 6;
    localparam int CTRL_ALU_OP_LO = 9;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       rs1_data;
        logic [31:0]       rs2_data;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input alu_op_e    alu_op,
        input logic [2:0] funct3,
        input logic       src_imm,
        input logic       mem_read,
        input logic       mem_write,
        input logic       reg_write,
        input logic       link,
        input logic       illegal
    );
        return {alu_op, funct3, src_imm, mem_read, mem_write, reg_write, link, illegal};
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file, two read ports and one write port. x0 reads as zero
// and ignores writes; a read of the register being written this cycle
// returns the incoming write data (write-first bypass).
module id_regfile
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    logic [31:0] regs [0:31];

    // Register write on the rising edge; x0 is never stored
    always_ff @(posedge clk) begin
        if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read port 1 with x0 forcing and same-cycle writeback bypass
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = 32'd0;
        end else if (wb_en && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    // Read port 2 with x0 forcing and same-cycle writeback bypass
    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = 32'd0;
        end else if (wb_en && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, register read, immediate generation, early
// jump/branch resolution back to IF, hazard stalls and the ID/EX register.
// Optional macro RV32M_DECODE_EN: decode MUL..REMU (OP, funct7=0000001)
// as alu_op 8..15; without it those encodings are flagged illegal.
module id_stage
    import rv32_pkg::*;
#(
    parameter int SQUASH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_instruction,
    input  logic [31:0]       if_pc,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_stall,
    output logic              jump_flag_id,
    output logic [31:0]       jump_address_id,
    output logic              stall_if,
    output logic              id_ex_valid,
    output logic [31:0]       id_ex_pc,
    output logic [31:0]       id_ex_rs1_data,
    output logic [31:0]       id_ex_rs2_data,
    output logic [31:0]       id_ex_imm,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [4:0]        id_ex_rd,
    output logic [CTRL_W-1:0] id_ex_ctrl
);

    localparam int CNT_W = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = if_instruction[6:0];
    assign rd     = if_instruction[11:7];
    assign funct3 = if_instruction[14:12];
    assign rs1    = if_instruction[19:15];
    assign rs2    = if_instruction[24:20];
    assign funct7 = if_instruction[31:25];

    assign imm_i = {{20{if_instruction[31]}}, if_instruction[31:20]};
    assign imm_s = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
    assign imm_b = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                    if_instruction[30:25], if_instruction[11:8], 1'b0};
    assign imm_u = {if_instruction[31:12], 12'd0};
    assign imm_j = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                    if_instruction[20], if_instruction[30:21], 1'b0};

    logic [31:0] rs1_rdata, rs2_rdata;

    id_regfile u_regfile (
        .clk      (clk),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_rdata),
        .rs2_data (rs2_rdata),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    // funct3 (plus the funct7 alternate bit) to base ALU operation
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            default: return ALU_LOGIC;
        endcase
    endfunction

    alu_op_e     alu_op;
    logic        src_imm, mem_read, mem_write, reg_write, link, illegal;
    logic        rs1_used, rs2_used, is_branch, is_jal, is_jalr;
    logic [31:0] imm;

    // Instruction decode; anything unrecognised collapses to a bare illegal flag
    always_comb begin
        alu_op    = ALU_ADD;
        src_imm   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        link      = 1'b0;
        illegal   = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        imm       = 32'd0;
        case (opcode)
            OPC_LUI: begin
                reg_write = 1'b1;
                src_imm   = 1'b1;
                imm       = imm_u;
            end
            // AUIPC is resolved here: EX sees 0 + (pc + immU)
            OPC_AUIPC: begin
                reg_write = 1'b1;
                src_imm   = 1'b1;
                imm       = if_pc + imm_u;
            end
            OPC_JAL: begin
                reg_write = 1'b1;
                link      = 1'b1;
                is_jal    = 1'b1;
                imm       = imm_j;
            end
            OPC_JALR: begin
                reg_write = 1'b1;
                link      = 1'b1;
                is_jalr   = 1'b1;
                rs1_used  = 1'b1;
                imm       = imm_i;
                illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                imm       = imm_b;
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                mem_read  = 1'b1;
                reg_write = 1'b1;
                src_imm   = 1'b1;
                rs1_used  = 1'b1;
                imm       = imm_i;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                src_imm   = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                imm       = imm_s;
                illegal   = (funct3[2] == 1'b1) || (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                reg_write = 1'b1;
                src_imm   = 1'b1;
                rs1_used  = 1'b1;
                imm       = imm_i;
                alu_op    = base_alu_op(funct3, 1'b0);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    alu_op  = base_alu_op(funct3, funct7[5]);
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                reg_write = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                if (funct7 == 7'b0000000) begin
                    alu_op = base_alu_op(funct3, 1'b0);
                end else if ((funct7 == 7'b0100000) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    alu_op = base_alu_op(funct3, 1'b1);
`ifdef RV32M_DECODE_EN
                end else if (funct7 == 7'b0000001) begin
                    alu_op = alu_op_e'({1'b1, funct3});
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE: ordering is trivially met in this in-order pipe
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_op    = ALU_ADD;
            src_imm   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            link      = 1'b0;
            rs1_used  = 1'b0;
            rs2_used  = 1'b0;
            is_branch = 1'b0;
            is_jal    = 1'b0;
            is_jalr   = 1'b0;
            imm       = 32'd0;
        end
    end

    logic signed [31:0] rs1_s, rs2_s;
    logic               br_cond;

    assign rs1_s = rs1_rdata;
    assign rs2_s = rs2_rdata;

    // Branch condition on the bypassed register values
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_rdata == rs2_rdata);
            3'b001:  br_cond = (rs1_rdata != rs2_rdata);
            3'b100:  br_cond = (rs1_s < rs2_s);
            3'b101:  br_cond = (rs1_s >= rs2_s);
            3'b110:  br_cond = (rs1_rdata < rs2_rdata);
            3'b111:  br_cond = (rs1_rdata >= rs2_rdata);
            default: br_cond = 1'b0;
        endcase
    end

    logic [CNT_W-1:0] squash_cnt;
    logic             squashed, src_match, hazard, taken;

    assign squashed  = (squash_cnt != '0);
    assign src_match = (ex_rd != 5'd0) &&
                       ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    // Load-use always stalls; branches/JALR resolve here, so any EX producer stalls them
    assign hazard    = !squashed && src_match &&
                       (ex_mem_read || ((is_branch || is_jalr) && ex_reg_write));
    assign taken     = is_jal || is_jalr || (is_branch && br_cond);

    assign jump_flag_id    = !rst && !squashed && !hazard && !ex_stall && taken;
    assign jump_address_id = is_jalr ? ((rs1_rdata + imm_i) & ~32'd1) :
                             is_jal  ? (if_pc + imm_j) :
                                       (if_pc + imm_b);
    assign stall_if        = !rst && (ex_stall || hazard);

    // Squash counter: drops the wrong-path fetches that follow a taken jump
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_cnt <= '0;
        end else if (!ex_stall) begin
            if (jump_flag_id) begin
                squash_cnt <= CNT_W'(SQUASH_CYCLES);
            end else if (squashed) begin
                squash_cnt <= squash_cnt - CNT_W'(1);
            end
        end
    end

    id_ex_t word_p0, id_ex_p1;

    // Assemble the ID/EX word; unused source fields are zeroed so EX never forwards on them
    always_comb begin
        word_p0          = '0;
        word_p0.valid    = 1'b1;
        word_p0.pc       = if_pc;
        word_p0.rs1      = rs1_used ? rs1 : 5'd0;
        word_p0.rs2      = rs2_used ? rs2 : 5'd0;
        word_p0.rs1_data = rs1_used ? rs1_rdata : 32'd0;
        word_p0.rs2_data = rs2_used ? rs2_rdata : 32'd0;
        word_p0.imm      = imm;
        word_p0.rd       = reg_write ? rd : 5'd0;
        word_p0.ctrl     = pack_ctrl(alu_op, illegal ? 3'b000 : funct3, src_imm,
                                     mem_read, mem_write, reg_write, link, illegal);
    end

    // ---- ID/EX boundary ----
    // ID/EX register: holds under ex_stall, bubbles on hazard or squash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_p1 <= '0;
        end else if (!ex_stall) begin
            id_ex_p1 <= (squashed || hazard) ? '0 : word_p0;
        end
    end

    assign id_ex_valid    = id_ex_p1.valid;
    assign id_ex_pc       = id_ex_p1.pc;
    assign id_ex_rs1_data = id_ex_p1.rs1_data;
    assign id_ex_rs2_data = id_ex_p1.rs2_data;
    assign id_ex_imm      = id_ex_p1.imm;
    assign id_ex_rs1      = id_ex_p1.rs1;
    assign id_ex_rs2      = id_ex_p1.rs2;
    assign id_ex_rd       = id_ex_p1.rd;
    assign id_ex_ctrl     = id_ex_p1.ctrl;

endmodule
